bp_ctrl: RTL and testbench

Branch-prediction controller that sequences the pattern history table (PHT) for the pipeline. Forms gshare indices from the fetch PC and a speculative global history register (GHR), and tracks in-flight predicted branches in an in-order queue. Issues exactly one PHT counter update per resolved branch and repairs the GHR on a misprediction. Sits between the fetch stage, the branch-resolution (MEM) stage and the PHT.

---
 rtl/bp_ctrl.sv | 103 ++++++++++
 tb/tb_bp_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_ctrl.sv
// gshare index/prediction path, speculative GHR, and an in-order queue of in-flight predicted branches.
// Prediction/update outputs are combinational, state moves on the next edge; fetch stalls while the queue is full.
module bp_ctrl #(
  parameter int width = 15,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic             fetch_is_br,
  input  logic [15:0]      fetch_pc,
  output logic             pred_taken,
  output logic             stall_fetch,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             mispredict,
  output logic [width-1:0] pht_index_fetch,
  input  logic             pht_out,
  output logic             pht_load,
  output logic [width-1:0] pht_index_mem,
  output logic             pht_ben,
  output logic [15:0]      br_count,
  output logic [15:0]      mp_count
);

  localparam int PW = $clog2(depth);
  localparam logic [PW:0] FULL = (PW+1)'(depth);

  typedef struct packed {
    logic [width-1:0] idx;
    logic             pred;
    logic [width-1:0] ghr;
  } entry_t;

  entry_t           q [depth];
  entry_t           head_e;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic [width-1:0] ghr;
  logic             nonempty;
  logic             resolve;
  logic             push;
  logic             unused_bits;

  assign head_e          = q[head];
  assign nonempty        = (count != '0);
  assign stall_fetch     = (count == FULL);
  assign resolve         = res_valid & nonempty;
  assign mispredict      = resolve & (res_taken != head_e.pred);
  assign push            = fetch_valid & fetch_is_br & ~stall_fetch & ~mispredict;

  assign pht_index_fetch = fetch_pc[width:1] ^ ghr;
  assign pred_taken      = pht_out;
  assign pht_load        = resolve & ~reset;
  assign pht_index_mem   = head_e.idx;
  assign pht_ben         = res_taken;

  // The oldest history bit of a saved GHR is shifted out on repair.
  assign unused_bits     = ^{fetch_pc, head_e.ghr[width-1]};

  // Entry storage carries no reset; validity is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      q[tail] <= '{idx: pht_index_fetch, pred: pht_out, ghr: ghr};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      ghr      <= '0;
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (mispredict) begin
        // Squash every younger branch and rebuild history from the mispredicted one.
        ghr   <= {head_e.ghr[width-2:0], res_taken};
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PW'(1);
          ghr  <= {ghr[width-2:0], pht_out};
        end
        if (resolve) begin
          head <= head + PW'(1);
        end
        count <= count + (PW+1)'(push) - (PW+1)'(resolve);
      end
      if (resolve && br_count != 16'hFFFF) begin
        br_count <= br_count + 16'd1;
      end
      if (mispredict && mp_count != 16'hFFFF) begin
        mp_count <= mp_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bp_ctrl.sv
// Randomized and directed bench for bp_ctrl against a queue-based reference model.
module tb_bp_ctrl;

  localparam int W    = 15;
  localparam int D    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_valid;
  logic         fetch_is_br;
  logic [15:0]  fetch_pc;
  logic         pred_taken;
  logic         stall_fetch;
  logic         res_valid;
  logic         res_taken;
  logic         mispredict;
  logic [W-1:0] pht_index_fetch;
  logic         pht_out;
  logic         pht_load;
  logic [W-1:0] pht_index_mem;
  logic         pht_ben;
  logic [15:0]  br_count;
  logic [15:0]  mp_count;

  always #5 clk = ~clk;

  bp_ctrl #(.width(W), .depth(D)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_is_br     (fetch_is_br),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .stall_fetch     (stall_fetch),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .mispredict      (mispredict),
    .pht_index_fetch (pht_index_fetch),
    .pht_out         (pht_out),
    .pht_load        (pht_load),
    .pht_index_mem   (pht_index_mem),
    .pht_ben         (pht_ben),
    .br_count        (br_count),
    .mp_count        (mp_count)
  );

  typedef struct {
    int idx;
    bit pred;
    int ghr;
  } ent_t;

  ent_t mq[$];
  int   m_ghr = 0;
  int   m_br  = 0;
  int   m_mp  = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   quiet = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit fv, input bit fb, input logic [15:0] pc,
                       input bit po, input bit rv, input bit rt);
    reset       = rst;
    fetch_valid = fv;
    fetch_is_br = fb;
    fetch_pc    = pc;
    pht_out     = po;
    res_valid   = rv;
    res_taken   = rt;
  endtask

  // One clock: drive, check combinational outputs vs model, clock, advance model.
  task automatic cyc(input bit rst, input bit fv, input bit fb, input logic [15:0] pc,
                     input bit po, input bit rv, input bit rt);
    int   exp_idx;
    bit   full, ne, mp, psh, res, ld;
    ent_t e;
    drive(rst, fv, fb, pc, po, rv, rt);
    #1;
    exp_idx = ((int'(pc) >> 1) & MASK) ^ m_ghr;
    full    = (mq.size() == D);
    ne      = (mq.size() != 0);
    mp      = rv && ne && (rt != mq[0].pred);
    ld      = rv && ne && !rst;
    if (!quiet) begin
      chk("pred_taken", int'(pred_taken), int'(po));
      chk("pht_index_fetch", int'(pht_index_fetch), exp_idx);
      chk("stall_fetch", int'(stall_fetch), int'(full));
      chk("mispredict", int'(mispredict), int'(mp));
      chk("pht_load", int'(pht_load), int'(ld));
      if (ld) begin
        chk("pht_index_mem", int'(pht_index_mem), mq[0].idx);
        chk("pht_ben", int'(pht_ben), int'(rt));
      end
      chk("br_count", int'(br_count), m_br);
      chk("mp_count", int'(mp_count), m_mp);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ghr = 0;
      m_br  = 0;
      m_mp  = 0;
    end else begin
      psh     = fv && fb && !full && !mp;
      res     = rv && ne;
      e.idx   = exp_idx;
      e.pred  = po;
      e.ghr   = m_ghr;
      if (res && m_br < 65535) m_br++;
      if (mp) begin
        if (m_mp < 65535) m_mp++;
        m_ghr = ((mq[0].ghr << 1) | int'(rt)) & MASK;
        mq.delete();
      end else begin
        if (res) void'(mq.pop_front());
        if (psh) begin
          mq.push_back(e);
          m_ghr = ((m_ghr << 1) | int'(po)) & MASK;
        end
      end
    end
    @(negedge clk);
  endtask

  // With fetch_pc = 0 the fetch index exposes the GHR directly.
  task automatic probe_ghr(input string tag, input int exp);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    #1;
    chk(tag, int'(pht_index_fetch), exp);
  endtask

  initial begin
    bit rv, rt;
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 1, 0);

    // Reset state and first fetch
    probe_ghr("rst_ghr", 0);
    chk("rst_stall", int'(stall_fetch), 0);
    chk("rst_br", int'(br_count), 0);
    chk("rst_mp", int'(mp_count), 0);
    drive(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    #1;
    chk("first_idx", int'(pht_index_fetch), 16'h0008);
    chk("first_pred", int'(pred_taken), 0);
    cyc(0, 1, 1, 16'h0010, 0, 0, 0);
    probe_ghr("first_ghr", 0);

    // Fill with taken predictions, hold the fifth, release with one resolve
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 16'($urandom), 1, 0, 0);
    probe_ghr("full_ghr", 16'h000F);
    chk("full_stall", int'(stall_fetch), 1);
    cyc(0, 1, 1, 16'h1234, 0, 0, 0);
    probe_ghr("held_ghr", 16'h000F);
    cyc(0, 0, 0, 16'h0, 0, 1, 1);
    chk("unstall", int'(stall_fetch), 0);

    // Mispredict on a head whose saved GHR is 3
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    cyc(0, 1, 1, 16'h0, 1, 0, 0);
    cyc(0, 1, 1, 16'h0, 1, 0, 0);
    cyc(0, 1, 1, 16'h0, 1, 1, 1);
    cyc(0, 0, 0, 16'h0, 0, 1, 1);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    #1;
    chk("mp_flag", int'(mispredict), 1);
    chk("mp_load", int'(pht_load), 1);
    chk("mp_ben", int'(pht_ben), 0);
    cyc(0, 0, 0, 16'h0, 0, 1, 0);
    probe_ghr("mp_ghr", 16'h0006);
    chk("mp_count1", int'(mp_count), 1);
    chk("mp_br", int'(br_count), 3);
    chk("mp_empty_stall", int'(stall_fetch), 0);

    // Resolve with an empty queue
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    #1;
    chk("empty_load", int'(pht_load), 0);
    cyc(0, 0, 0, 16'h0, 0, 1, 1);
    chk("empty_br", int'(br_count), 3);
    chk("empty_mp", int'(mp_count), 1);

    // Simultaneous push and correct resolve at occupancy 2
    cyc(0, 1, 1, 16'h0020, 1, 0, 0);
    cyc(0, 1, 1, 16'h0040, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 16'h0080, 1'b1, 1'b1, 1'b1);
    #1;
    chk("pr_mem_idx", int'(pht_index_mem), 16'h0016);
    chk("pr_fetch_idx", int'(pht_index_fetch), 16'h005A);
    chk("pr_no_mp", int'(mispredict), 0);
    cyc(0, 1, 1, 16'h0080, 1, 1, 1);
    cyc(0, 1, 1, 16'h0100, 0, 0, 0);
    chk("pr_occ3", int'(stall_fetch), 0);
    cyc(0, 1, 1, 16'h0200, 0, 0, 0);
    chk("pr_occ4", int'(stall_fetch), 1);

    // Reset with three queued entries
    cyc(0, 0, 0, 16'h0, 0, 1, 0);
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    probe_ghr("mid_rst_ghr", 0);
    chk("mid_rst_br", int'(br_count), 0);
    chk("mid_rst_mp", int'(mp_count), 0);
    chk("mid_rst_stall", int'(stall_fetch), 0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    #1;
    chk("mid_rst_load", int'(pht_load), 0);

    // Randomized traffic, mostly-correct resolves, occasional reset
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom % 2) == 1;
      if (mq.size() != 0 && ($urandom % 4) != 0) rt = mq[0].pred;
      else rt = ($urandom % 2) == 1;
      cyc(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
          16'($urandom), ($urandom % 2) == 1, rv, rt);
    end

    // Drive br_count to saturation with back-to-back push+resolve
    cyc(1, 0, 0, 16'h0, 0, 0, 0);
    cyc(0, 1, 1, 16'h0, 1, 0, 0);
    quiet = 1'b1;
    for (int i = 0; i < 65535; i++) cyc(0, 1, 1, 16'h0, 1, 1, 1);
    quiet = 1'b0;
    chk("sat_br_max", int'(br_count), 16'hFFFF);
    cyc(0, 1, 1, 16'h0, 1, 1, 1);
    chk("sat_br_hold", int'(br_count), 16'hFFFF);
    chk("sat_mp", int'(mp_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
